reimu_life_ctrl: RTL and testbench
==================================

Name: reimu_life_ctrl

Overview:
Player-lifecycle controller that sequences the player sprite block through start, play, death, respawn, invulnerability and game-over. It owns lives, bombs, bomb timing and the hit-ignore windows. It drives the gameover level consumed by the player movement block, and the visibility, invincibility and HUD signals consumed by the renderer and collision logic. It runs on the game-tick clock.

Parameters:
LIVES_INIT, 3, lives loaded on game start (1..7)
BOMBS_INIT, 3, bombs loaded on start and on each respawn (0..7)
DEATH_TICKS, 16, ticks spent in DYING (1..255)
INVULN_TICKS, 48, ticks of post-respawn invulnerability (1..255)
BOMB_TICKS, 32, ticks a bomb stays active (1..255)
BLINK_BIT, 1, tick-counter bit that drives the blink during INVULN (0..7)

Ports:
clk22  in  1  game-tick clock; all state changes on its rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  menu start/confirm, level; rising edge used
hit  in  1  collision from the bullet/player overlap logic, level, sampled each tick
bomb_btn  in  1  bomb key, level; rising edge used
pause  in  1  freeze all game-time progress while high
gameover  out  1  high in OVER and in IDLE; holds the player position at its home point
respawn  out  1  one-tick pulse on game start and on each respawn
visible  out  1  player sprite enable
invincible  out  1  hits ignored (INVULN or bomb active)
bomb_active  out  1  bomb effect running
lives  out  3  remaining lives
bombs  out  3  remaining bombs
state  out  3  IDLE=0, PLAY=1, DYING=2, INVULN=3, OVER=4

Behaviour:
- Reset (rst_n=0, asynchronous) sets:
  - state=IDLE, lives=LIVES_INIT, bombs=BOMBS_INIT
  - all timers=0, edge-detect registers=0, bomb_active=0, respawn=0
- Outputs are registered except gameover, visible and invincible, which decode combinationally from registered state.
- Edge detection: start_q and bomb_q update every tick, including during pause. An edge whose tick has pause=1 is discarded.
- pause=1: state, timers, lives, bombs and bomb_active all hold. respawn=0. hit is ignored.
- IDLE: gameover=1, visible=0. A start edge:
  - goes to PLAY
  - loads lives=LIVES_INIT and bombs=BOMBS_INIT
  - pulses respawn in the next tick
- PLAY: visible=1.
  - A bomb edge with bombs>0 and bomb_active=0 sets bomb_active=1, loads the bomb timer to BOMB_TICKS and decrements bombs.
  - The bomb timer decrements every tick. bomb_active clears on the tick the timer reaches 1, so it is high for exactly BOMB_TICKS ticks.
  - hit=1 with invincible=0 goes to DYING, decrements lives (saturating at 0) and loads the state timer to DEATH_TICKS.
  - A bomb edge and hit in the same tick: the bomb wins, hit is ignored, no death.
  - A bomb edge with bombs=0 is a no-op.
- DYING: visible=0, invincible=0, hit ignored, bomb edges ignored. Any running bomb_active is cleared on entry. After DEATH_TICKS ticks:
  - lives==0: go to OVER
  - else: go to INVULN, pulse respawn, reload bombs=BOMBS_INIT, load the state timer to INVULN_TICKS
- INVULN: invincible=1, hit ignored.
  - visible = timer[BLINK_BIT].
  - Bombs are usable with the same rules as PLAY.
  - After INVULN_TICKS ticks, go to PLAY. A bomb still running continues into PLAY.
- OVER: gameover=1, visible=0, lives=0.
  - A start edge restarts the game exactly as from IDLE.
  - hit and bomb edges are ignored.
- invincible = (state==INVULN) | bomb_active.
- Timers are 8-bit down-counters; they never wrap below 0.
- respawn is never high for 2 consecutive ticks.

Test Plan:
- Reset mid-INVULN (rst_n low between edges) -> outputs go to IDLE values immediately: lives=3, bombs=3, gameover=1, bomb_active=0, no respawn.
- Start edge from IDLE -> state=1 and respawn=1 exactly the next tick; lives=3, bombs=3, gameover=0, visible=1.
- PLAY, hit for 1 tick -> state=2, lives=2, visible=0 for 16 ticks; then state=3 with a respawn pulse; visible toggles every 2 ticks; a hit during INVULN does not change lives; state=1 after 48 ticks.
- PLAY, bomb edge and hit in the same tick -> no death; bombs=2; bomb_active high for exactly 32 ticks; hits during that window ignored; 4 bomb presses leave bombs=0 with the 4th a no-op.
- 3 deaths from LIVES_INIT=3 -> after the third DYING, state=4 and gameover=1; a later start edge reloads lives=3 and bombs=3 and returns to PLAY.
- pause=1 for 10 ticks mid-DYING and mid-bomb -> timers hold, no transitions; a bomb edge during pause is discarded; bomb_btn held through the pause release produces no bomb.

Source files
------------

// File: rtl/reimu_life_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : reimu_life_ctrl
// Purpose  : Player lifecycle sequencer - lives, bombs, death/respawn timing.
// Revision : 1.0 - initial release
// ============================================================================
module reimu_life_ctrl #(
    parameter int LIVES_INIT   = 3,
    parameter int BOMBS_INIT   = 3,
    parameter int DEATH_TICKS  = 16,
    parameter int INVULN_TICKS = 48,
    parameter int BOMB_TICKS   = 32,
    parameter int BLINK_BIT    = 1
) (
    input  logic       clk22,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hit,
    input  logic       bomb_btn,
    input  logic       pause,
    output logic       gameover,
    output logic       respawn,
    output logic       visible,
    output logic       invincible,
    output logic       bomb_active,
    output logic [2:0] lives,
    output logic [2:0] bombs,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PLAY   = 3'd1,
        S_DYING  = 3'd2,
        S_INVULN = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    localparam logic [2:0] c_lives_init   = 3'(LIVES_INIT);
    localparam logic [2:0] c_bombs_init   = 3'(BOMBS_INIT);
    localparam logic [7:0] c_death_ticks  = 8'(DEATH_TICKS);
    localparam logic [7:0] c_invuln_ticks = 8'(INVULN_TICKS);
    localparam logic [7:0] c_bomb_ticks   = 8'(BOMB_TICKS);

    state_t     r_state,       w_state_nxt;
    logic [2:0] r_lives,       w_lives_nxt;
    logic [2:0] r_bombs,       w_bombs_nxt;
    logic [7:0] r_state_tmr,   w_state_tmr_nxt;
    logic [7:0] r_bomb_tmr,    w_bomb_tmr_nxt;
    logic       r_bomb_active, w_bomb_active_nxt;
    logic       r_respawn,     w_respawn_nxt;
    logic       r_start_q;
    logic       r_bomb_q;

    logic       w_start_edge;
    logic       w_bomb_edge;
    logic       w_bomb_fire;
    logic       w_invincible;

    // Edges seen while paused are dropped, but the delay flops still track
    // the buttons so a key held across the pause release is not a new press.
    assign w_start_edge = start & ~r_start_q & ~pause;
    assign w_bomb_edge  = bomb_btn & ~r_bomb_q & ~pause;
    assign w_bomb_fire  = w_bomb_edge & (r_bombs != 3'd0) & ~r_bomb_active;
    assign w_invincible = (r_state == S_INVULN) | r_bomb_active;

    always_ff @(posedge clk22 or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_lives       <= c_lives_init;
            r_bombs       <= c_bombs_init;
            r_state_tmr   <= 8'd0;
            r_bomb_tmr    <= 8'd0;
            r_bomb_active <= 1'b0;
            r_respawn     <= 1'b0;
            r_start_q     <= 1'b0;
            r_bomb_q      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_lives       <= w_lives_nxt;
            r_bombs       <= w_bombs_nxt;
            r_state_tmr   <= w_state_tmr_nxt;
            r_bomb_tmr    <= w_bomb_tmr_nxt;
            r_bomb_active <= w_bomb_active_nxt;
            r_respawn     <= w_respawn_nxt;
            r_start_q     <= start;
            r_bomb_q      <= bomb_btn;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_lives_nxt       = r_lives;
        w_bombs_nxt       = r_bombs;
        w_state_tmr_nxt   = r_state_tmr;
        w_bomb_tmr_nxt    = r_bomb_tmr;
        w_bomb_active_nxt = r_bomb_active;
        w_respawn_nxt     = 1'b0;

        if (!pause) begin
            // Clearing on the count of 1 keeps bomb_active high for exactly BOMB_TICKS ticks.
            if (r_bomb_active) begin
                if (r_bomb_tmr <= 8'd1) begin
                    w_bomb_tmr_nxt    = 8'd0;
                    w_bomb_active_nxt = 1'b0;
                end else begin
                    w_bomb_tmr_nxt = r_bomb_tmr - 8'd1;
                end
            end

            case (r_state)
                S_IDLE, S_OVER: begin
                    if (w_start_edge) begin
                        w_state_nxt       = S_PLAY;
                        w_lives_nxt       = c_lives_init;
                        w_bombs_nxt       = c_bombs_init;
                        w_state_tmr_nxt   = 8'd0;
                        w_bomb_tmr_nxt    = 8'd0;
                        w_bomb_active_nxt = 1'b0;
                        w_respawn_nxt     = 1'b1;
                    end
                end
                S_PLAY: begin
                    if (w_bomb_fire) begin
                        w_bomb_active_nxt = 1'b1;
                        w_bomb_tmr_nxt    = c_bomb_ticks;
                        w_bombs_nxt       = r_bombs - 3'd1;
                    end else if (hit && !w_invincible) begin
                        w_state_nxt       = S_DYING;
                        w_lives_nxt       = (r_lives == 3'd0) ? 3'd0 : r_lives - 3'd1;
                        w_state_tmr_nxt   = c_death_ticks;
                        w_bomb_active_nxt = 1'b0;
                        w_bomb_tmr_nxt    = 8'd0;
                    end
                end
                S_DYING: begin
                    if (r_state_tmr <= 8'd1) begin
                        if (r_lives == 3'd0) begin
                            w_state_nxt     = S_OVER;
                            w_state_tmr_nxt = 8'd0;
                        end else begin
                            w_state_nxt     = S_INVULN;
                            w_respawn_nxt   = 1'b1;
                            w_bombs_nxt     = c_bombs_init;
                            w_state_tmr_nxt = c_invuln_ticks;
                        end
                    end else begin
                        w_state_tmr_nxt = r_state_tmr - 8'd1;
                    end
                end
                S_INVULN: begin
                    if (w_bomb_fire) begin
                        w_bomb_active_nxt = 1'b1;
                        w_bomb_tmr_nxt    = c_bomb_ticks;
                        w_bombs_nxt       = r_bombs - 3'd1;
                    end
                    if (r_state_tmr <= 8'd1) begin
                        w_state_nxt     = S_PLAY;
                        w_state_tmr_nxt = 8'd0;
                    end else begin
                        w_state_tmr_nxt = r_state_tmr - 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        visible = 1'b0;
        case (r_state)
            S_PLAY:   visible = 1'b1;
            S_INVULN: visible = r_state_tmr[BLINK_BIT];
            default:  visible = 1'b0;
        endcase
    end

    assign gameover    = (r_state == S_IDLE) | (r_state == S_OVER);
    assign invincible  = w_invincible;
    assign respawn     = r_respawn;
    assign bomb_active = r_bomb_active;
    assign lives       = r_lives;
    assign bombs       = r_bombs;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_reimu_life_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_reimu_life_ctrl
// Purpose  : Scoreboard bench for reimu_life_ctrl with directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reimu_life_ctrl;

    logic       clk22 = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       hit = 1'b0;
    logic       bomb_btn = 1'b0;
    logic       pause = 1'b0;
    logic       gameover, respawn, visible, invincible, bomb_active;
    logic [2:0] lives, bombs, state;

    always #5 clk22 = ~clk22;

    reimu_life_ctrl #(
        .LIVES_INIT   (3),
        .BOMBS_INIT   (3),
        .DEATH_TICKS  (16),
        .INVULN_TICKS (48),
        .BOMB_TICKS   (32),
        .BLINK_BIT    (1)
    ) dut (
        .clk22       (clk22),
        .rst_n       (rst_n),
        .start       (start),
        .hit         (hit),
        .bomb_btn    (bomb_btn),
        .pause       (pause),
        .gameover    (gameover),
        .respawn     (respawn),
        .visible     (visible),
        .invincible  (invincible),
        .bomb_active (bomb_active),
        .lives       (lives),
        .bombs       (bombs),
        .state       (state)
    );

    logic [13:0] exp_q[$];
    string       name_q[$];
    int          errors = 0;
    int          checks = 0;

    logic [2:0] x_st, x_lv, x_bm;
    logic       x_rsp, x_vis, x_inv, x_ba;

    function automatic logic [13:0] pk(input logic [2:0] st, lv, bm,
                                       input logic rsp, vis, inv, ba);
        logic go;
        go = (st == 3'd0) || (st == 3'd4);
        return {st, lv, bm, go, rsp, vis, inv, ba};
    endfunction

    task automatic setx(input logic [2:0] st, lv, bm, input logic rsp, vis, inv, ba);
        x_st = st; x_lv = lv; x_bm = bm;
        x_rsp = rsp; x_vis = vis; x_inv = inv; x_ba = ba;
    endtask

    task automatic expect_now(input string nm);
        exp_q.push_back(pk(x_st, x_lv, x_bm, x_rsp, x_vis, x_inv, x_ba));
        name_q.push_back(nm);
    endtask

    // One game tick: drive inputs, let the edge happen, queue what must follow it.
    task automatic cyc(input logic s, h, b, p, input string nm);
        @(negedge clk22);
        start = s; hit = h; bomb_btn = b; pause = p;
        @(posedge clk22);
        expect_now(nm);
    endtask

    initial begin : monitor
        logic [13:0] e, a;
        string       n;
        forever begin
            @(negedge clk22);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                a = {state, lives, bombs, gameover, respawn, visible, invincible, bomb_active};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s @%0t: got st=%0d lv=%0d bm=%0d go/rsp/vis/inv/ba=%b, expected st=%0d lv=%0d bm=%0d go/rsp/vis/inv/ba=%b",
                             n, $time, a[13:11], a[10:8], a[7:5], a[4:0],
                             e[13:11], e[10:8], e[7:5], e[4:0]);
                end
            end
        end
    end

    task automatic death_respawn(input logic [2:0] lv_before, input logic [2:0] bm_before);
        logic [2:0] lv;
        lv = lv_before - 3'd1;
        setx(3'd2, lv, bm_before, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "hit_to_dying");
        for (int i = 1; i <= 15; i++)
            cyc(1'b0, i == 5, i == 7, 1'b0, "dying_hold");
        if (lv == 3'd0) begin
            setx(3'd4, 3'd0, bm_before, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, "dying_to_over");
        end else begin
            setx(3'd3, lv, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, "dying_to_invuln");
            for (int i = 1; i <= 47; i++) begin
                setx(3'd3, lv, 3'd3, 1'b0, 1'(((48 - i) >> 1) & 1), 1'b1, 1'b0);
                cyc(1'b0, i == 10, 1'b0, 1'b0, "invuln_blink");
            end
            setx(3'd1, lv, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, "invuln_to_play");
        end
    endtask

    task automatic bomb_run(input logic [2:0] lv, input logic [2:0] bm_after, input logic with_hit);
        setx(3'd1, lv, bm_after, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, with_hit, 1'b1, 1'b0, "bomb_fire");
        for (int i = 1; i <= 31; i++)
            cyc(1'b0, (i == 3) || (i == 20), i == 10, 1'b0, "bomb_active_hold");
        setx(3'd1, lv, bm_after, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "bomb_expire");
    endtask

    initial begin : stim
        setx(3'd0, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_now("reset");
        @(negedge clk22);
        #1 rst_n = 1'b1;

        setx(3'd1, 3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "start");
        setx(3'd1, 3'd3, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "start_held");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "play");

        death_respawn(3'd3, 3'd3);

        bomb_run(3'd2, 3'd2, 1'b1);
        bomb_run(3'd2, 3'd1, 1'b0);
        bomb_run(3'd2, 3'd0, 1'b0);
        setx(3'd1, 3'd2, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, "bomb_empty");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "bomb_empty_hold");

        death_respawn(3'd2, 3'd0);
        death_respawn(3'd1, 3'd3);
        setx(3'd4, 3'd0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, "over_ignore");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "over_hold");
        setx(3'd1, 3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "restart");
        setx(3'd1, 3'd3, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "restart_hold");

        // Bomb stretched by a 10-tick pause: 42 active ticks in total.
        setx(3'd1, 3'd3, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, "bomb_fire_p");
        for (int i = 1; i <= 5; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'b0, "bomb_pre_pause");
        for (int i = 1; i <= 10; i++)
            cyc(1'b0, i == 2, i >= 3, 1'b1, "bomb_paused");
        for (int i = 1; i <= 26; i++)
            cyc(1'b0, 1'b0, i <= 3, 1'b0, "bomb_after_pause");
        setx(3'd1, 3'd3, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "bomb_expire_p");

        // Death stretched by a 10-tick pause: 26 DYING ticks in total.
        setx(3'd2, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "hit_p");
        for (int i = 1; i <= 5; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'b0, "dying_pre_pause");
        for (int i = 1; i <= 10; i++)
            cyc(1'b0, 1'b1, 1'b0, 1'b1, "dying_paused");
        for (int i = 1; i <= 10; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'b0, "dying_after_pause");
        setx(3'd3, 3'd2, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "dying_to_invuln_p");

        setx(3'd3, 3'd2, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "invuln_47");
        setx(3'd3, 3'd2, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, "invuln_bomb");
        setx(3'd3, 3'd2, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "invuln_45");

        // Reset lands between edges; the next negedge must already show IDLE.
        @(negedge clk22);
        @(posedge clk22);
        #1 rst_n = 1'b0;
        setx(3'd0, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_now("async_reset");
        @(negedge clk22);
        #1 rst_n = 1'b1;

        setx(3'd0, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, "start_paused");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "start_held_after_pause");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "idle");
        setx(3'd1, 3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "start_final");
        setx(3'd1, 3'd3, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "play_final");

        @(negedge clk22);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
